io_pad_direction_arbiter: RTL and testbench

IO_PAD_DIRECTION_ARBITER -- requirements
Module: io_pad_direction_arbiter

---
 rtl/io_pad_direction_arbiter_if.sv | 30 +++
 rtl/io_pad_direction_arbiter.sv | 137 +++++++++++++
 tb/tb_io_pad_direction_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/io_pad_direction_arbiter_if.sv
// Purpose: bundles the requester, pad and status signals of io_pad_direction_arbiter.
// Latency: none; this is wiring only.
// Backpressure: none; a requester waits on its grant, and the arbiter never stalls.
interface io_pad_direction_arbiter_if;
    logic req_a;
    logic req_b;
    logic oe_a;
    logic oe_b;
    logic dout_a;
    logic dout_b;
    logic grant_a;
    logic grant_b;
    logic pad_o;
    logic pad_oe;
    logic pad_i;
    logic din;
    logic busy;

    // Requester and IO-cell side: drives requests, data and the pad input.
    modport master (
        output req_a, req_b, oe_a, oe_b, dout_a, dout_b, pad_i,
        input  grant_a, grant_b, pad_o, pad_oe, din, busy
    );

    // Arbiter side.
    modport slave (
        input  req_a, req_b, oe_a, oe_b, dout_a, dout_b, pad_i,
        output grant_a, grant_b, pad_o, pad_oe, din, busy
    );
endinterface

// File: rtl/io_pad_direction_arbiter.sv
// Purpose: arbitrates ownership of one bidirectional IO pad between requesters A and B, with turnaround gaps.
// Latency: a grant follows 1 cycle after the request is sampled; din lags pad_i by 1 cycle, or by 2 with IO_ARB_SYNC_EN.
// Backpressure: a waiting requester keeps req high until granted; the arbiter forces an owner off after MAX_HOLD cycles of contention.
module io_pad_direction_arbiter #(
    parameter int TA_CYCLES = 2,   // undriven cycles between owners, 1..15
    parameter int MAX_HOLD  = 16   // owner cycles allowed while the other side waits, 2..255
) (
    input  logic                         UserCLK,
    input  logic                         RST,
    io_pad_direction_arbiter_if.slave    bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN_A = 2'd1;
    localparam logic [1:0] ST_OWN_B = 2'd2;
    localparam logic [1:0] ST_TURN  = 2'd3;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam logic [3:0] TURN_LAST = 4'(TA_CYCLES - 1);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [7:0] hold_cnt;
    logic [3:0] turn_cnt;
    logic       last_b;     // 1 when B was the most recent owner, so A wins the next tie
    logic       pick_a;
    logic       pick_b;
    logic       din_q;

    // Pick a winner from the current requests; ties go to the side not granted most recently.
    always_comb begin
        pick_a = bus.req_a && (!bus.req_b || last_b);
        pick_b = bus.req_b && (!bus.req_a || !last_b);
    end

    // Next-state logic: an owner leaves on release or on pre-emption, and TURN arbitrates only in its last cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (pick_a) begin
                    state_nxt = ST_OWN_A;
                end else if (pick_b) begin
                    state_nxt = ST_OWN_B;
                end
            end
            ST_OWN_A: begin
                if (!bus.req_a || (bus.req_b && (hold_cnt == HOLD_LAST))) begin
                    state_nxt = ST_TURN;
                end
            end
            ST_OWN_B: begin
                if (!bus.req_b || (bus.req_a && (hold_cnt == HOLD_LAST))) begin
                    state_nxt = ST_TURN;
                end
            end
            default: begin
                if (turn_cnt == TURN_LAST) begin
                    if (pick_a) begin
                        state_nxt = ST_OWN_A;
                    end else if (pick_b) begin
                        state_nxt = ST_OWN_B;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
        endcase
    end

    // State register and round-robin pointer; the pointer moves whenever a new owner is granted.
    always_ff @(posedge UserCLK or posedge RST) begin
        if (RST) begin
            state  <= ST_IDLE;
            last_b <= 1'b1;
        end else begin
            state <= state_nxt;
            if ((state_nxt == ST_OWN_A) && (state != ST_OWN_A)) begin
                last_b <= 1'b0;
            end else if ((state_nxt == ST_OWN_B) && (state != ST_OWN_B)) begin
                last_b <= 1'b1;
            end
        end
    end

    // Hold and turn counters: cleared on every state change, hold saturates so lone owners keep the pad.
    always_ff @(posedge UserCLK or posedge RST) begin
        if (RST) begin
            hold_cnt <= '0;
            turn_cnt <= '0;
        end else if (state_nxt != state) begin
            hold_cnt <= '0;
            turn_cnt <= '0;
        end else begin
            if (((state == ST_OWN_A) || (state == ST_OWN_B)) && (hold_cnt != HOLD_LAST)) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
            if (state == ST_TURN) begin
                turn_cnt <= turn_cnt + 4'd1;
            end
        end
    end

`ifdef IO_ARB_SYNC_EN
    logic pad_i_meta;

    // Two-flop synchronizer for a pad input that may be asynchronous to UserCLK.
    always_ff @(posedge UserCLK or posedge RST) begin
        if (RST) begin
            pad_i_meta <= 1'b0;
            din_q      <= 1'b0;
        end else begin
            pad_i_meta <= bus.pad_i;
            din_q      <= pad_i_meta;
        end
    end
`else
    // Single capture register for the pad input, running in every state.
    always_ff @(posedge UserCLK or posedge RST) begin
        if (RST) begin
            din_q <= 1'b0;
        end else begin
            din_q <= bus.pad_i;
        end
    end
`endif

    // Grants come straight from the state register, so reset drops them and the pad drive at once.
    assign bus.grant_a = (state == ST_OWN_A);
    assign bus.grant_b = (state == ST_OWN_B);
    assign bus.pad_oe  = (bus.grant_a && bus.oe_a) || (bus.grant_b && bus.oe_b);
    assign bus.pad_o   = (bus.grant_a && bus.oe_a && bus.dout_a) ||
                         (bus.grant_b && bus.oe_b && bus.dout_b);
    assign bus.busy    = (state != ST_IDLE);
    assign bus.din     = din_q;

endmodule

// File: tb/tb_io_pad_direction_arbiter.sv
// Purpose: scoreboard bench for io_pad_direction_arbiter, driven by directed cycle tables and then random traffic.
// Latency: each table row lists what the outputs must show in the same cycle as the row's inputs.
// Backpressure: none; the stimulus process advances one row per clock.
module tb_io_pad_direction_arbiter;

    localparam int TA  = 2;
    localparam int MH  = 4;
`ifdef IO_ARB_SYNC_EN
    localparam int LAG = 2;
`else
    localparam int LAG = 1;
`endif

    typedef struct {
        int         due;
        int         row;
        string      tag;
        logic [4:0] ex;     // {grant_a, grant_b, pad_oe, pad_o, busy}
        logic       din;
    } exp_t;

    logic UserCLK;
    logic RST;
    int   cyc_n;
    int   row_n;
    int   n_cmp;
    int   n_bad;
    int   turn_run;
    bit   rand_phase;
    logic [1:0] pi_hist;
    exp_t sb_q[$];

    io_pad_direction_arbiter_if bus ();

    io_pad_direction_arbiter #(
        .TA_CYCLES (TA),
        .MAX_HOLD  (MH)
    ) dut (
        .UserCLK (UserCLK),
        .RST     (RST),
        .bus     (bus)
    );

    initial begin
        UserCLK = 1'b0;
        forever #5 UserCLK = ~UserCLK;
    end

    always @(posedge UserCLK) cyc_n <= cyc_n + 1;

    // Drive one cycle of inputs {req_a,req_b,oe_a,oe_b,dout_a,dout_b,pad_i} and queue the expected outputs.
    task automatic cyc(input string tag, input logic [6:0] in, input logic [4:0] ex, input bit rst_pulse);
        exp_t e;
        @(posedge UserCLK);
        #1;
        {bus.req_a, bus.req_b, bus.oe_a, bus.oe_b, bus.dout_a, bus.dout_b, bus.pad_i} = in;
        e.due = cyc_n;
        e.row = row_n;
        e.tag = tag;
        e.ex  = ex;
        if (rst_pulse) begin
            e.din   = 1'b0;
            pi_hist = 2'b00;
        end else begin
            e.din = (LAG == 1) ? pi_hist[0] : pi_hist[1];
        end
        pi_hist = {pi_hist[0], in[0]};
        row_n++;
        sb_q.push_back(e);
        if (rst_pulse) begin
            #1 RST = 1'b1;
            #5 RST = 1'b0;
        end
    endtask

    // Monitor: pops the scoreboard entry due this cycle, and checks invariants during random traffic.
    always @(negedge UserCLK) begin : mon
        exp_t       e;
        logic [4:0] act;
        act = {bus.grant_a, bus.grant_b, bus.pad_oe, bus.pad_o, bus.busy};
        while (sb_q.size() > 0 && sb_q[0].due < cyc_n) begin
            e = sb_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s row %0d: entry not observed (due cycle %0d, now %0d)", e.tag, e.row, e.due, cyc_n);
        end
        if (sb_q.size() > 0 && sb_q[0].due == cyc_n) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (act !== e.ex || bus.din !== e.din) begin
                n_bad++;
                $display("FAIL %s row %0d: got {gA,gB,oe,o,busy}=%b din=%b, want %b din=%b",
                         e.tag, e.row, act, bus.din, e.ex, e.din);
            end
        end
        if (rand_phase) begin
            n_cmp++;
            if (bus.grant_a && bus.grant_b) begin
                n_bad++;
                $display("FAIL excl cycle %0d: grant_a=%b grant_b=%b, want not both 1", cyc_n, bus.grant_a, bus.grant_b);
            end
            n_cmp++;
            if ((bus.pad_oe && !((bus.grant_a && bus.oe_a) || (bus.grant_b && bus.oe_b))) ||
                (bus.pad_o && !bus.pad_oe)) begin
                n_bad++;
                $display("FAIL drive cycle %0d: pad_oe=%b pad_o=%b with grants %b%b, want drive only by owner",
                         cyc_n, bus.pad_oe, bus.pad_o, bus.grant_a, bus.grant_b);
            end
            if (bus.busy && !bus.grant_a && !bus.grant_b) begin
                turn_run++;
            end else if (turn_run != 0) begin
                n_cmp++;
                if (turn_run != TA) begin
                    n_bad++;
                    $display("FAIL turn_len cycle %0d: got %0d, want %0d", cyc_n, turn_run, TA);
                end
                turn_run = 0;
            end
        end
    end

    initial begin
        cyc_n      = 0;
        row_n      = 0;
        n_cmp      = 0;
        n_bad      = 0;
        turn_run   = 0;
        rand_phase = 1'b0;
        pi_hist    = 2'b00;
        RST        = 1'b1;
        {bus.req_a, bus.req_b, bus.oe_a, bus.oe_b, bus.dout_a, bus.dout_b, bus.pad_i} = 7'b0;
        repeat (2) @(posedge UserCLK);
        #2 RST = 1'b0;

        // Lone owner A for 5 request cycles, then two undriven turnaround cycles.
        cyc("own_a", 7'b0000000, 5'b00000, 0);
        cyc("own_a", 7'b1010100, 5'b00000, 0);
        cyc("own_a", 7'b1010100, 5'b10111, 0);
        cyc("own_a", 7'b1010100, 5'b10111, 0);
        cyc("own_a", 7'b1010100, 5'b10111, 0);
        cyc("own_a", 7'b1010100, 5'b10111, 0);
        cyc("own_a", 7'b0010100, 5'b10111, 0);
        cyc("own_a", 7'b0010100, 5'b00001, 0);
        cyc("own_a", 7'b0010100, 5'b00001, 0);
        cyc("own_a", 7'b0000000, 5'b00000, 0);

        // Reset restores "B last", so a tie goes to A; B follows the turnaround with no IDLE cycle.
        cyc("tie", 7'b0000000, 5'b00000, 1);
        cyc("tie", 7'b1111010, 5'b00000, 0);
        cyc("tie", 7'b1111010, 5'b10101, 0);
        cyc("tie", 7'b0111010, 5'b10101, 0);
        cyc("tie", 7'b0111010, 5'b00001, 0);
        cyc("tie", 7'b0111010, 5'b00001, 0);
        cyc("tie", 7'b0100000, 5'b01001, 0);
        cyc("tie", 7'b0000000, 5'b01001, 0);
        cyc("tie", 7'b0000000, 5'b00001, 0);
        cyc("tie", 7'b0000000, 5'b00001, 0);
        cyc("tie", 7'b0000000, 5'b00000, 0);

        // A is pre-empted after 4 contended cycles, B owns, and A is re-granted when B releases.
        cyc("preempt", 7'b1010100, 5'b00000, 0);
        cyc("preempt", 7'b1110100, 5'b10111, 0);
        cyc("preempt", 7'b1110100, 5'b10111, 0);
        cyc("preempt", 7'b1110100, 5'b10111, 0);
        cyc("preempt", 7'b1110100, 5'b10111, 0);
        cyc("preempt", 7'b1110100, 5'b00001, 0);
        cyc("preempt", 7'b1110100, 5'b00001, 0);
        cyc("preempt", 7'b1111110, 5'b01111, 0);
        cyc("preempt", 7'b1011110, 5'b01111, 0);
        cyc("preempt", 7'b1010100, 5'b00001, 0);
        cyc("preempt", 7'b1010100, 5'b00001, 0);
        cyc("preempt", 7'b0010100, 5'b10111, 0);
        cyc("preempt", 7'b0000000, 5'b00001, 0);
        cyc("preempt", 7'b0000000, 5'b00001, 0);
        cyc("preempt", 7'b0000000, 5'b00000, 0);

        // A owns alone well past MAX_HOLD; the saturated counter pre-empts as soon as B asks.
        // The A-only request in the first TURN cycle must be ignored.
        cyc("sat", 7'b1010100, 5'b00000, 0);
        for (int i = 0; i < 6; i++) cyc("sat", 7'b1010100, 5'b10111, 0);
        cyc("sat", 7'b1110100, 5'b10111, 0);
        cyc("sat", 7'b1000000, 5'b00001, 0);
        cyc("sat", 7'b0100000, 5'b00001, 0);
        cyc("sat", 7'b0000000, 5'b01001, 0);
        cyc("sat", 7'b0000000, 5'b00001, 0);
        cyc("sat", 7'b0000000, 5'b00001, 0);
        cyc("sat", 7'b0000000, 5'b00000, 0);

        // Reset pulsed mid-OWN_B releases the pad before the next edge; the following tie goes to A.
        cyc("rst_own_b", 7'b0101010, 5'b00000, 0);
        cyc("rst_own_b", 7'b0101010, 5'b01111, 0);
        cyc("rst_own_b", 7'b1111010, 5'b00000, 1);
        cyc("rst_own_b", 7'b0010100, 5'b10111, 0);
        cyc("rst_own_b", 7'b0000000, 5'b00001, 0);
        cyc("rst_own_b", 7'b0000000, 5'b00001, 0);
        cyc("rst_own_b", 7'b0000000, 5'b00000, 0);

        // Toggle pad_i; din lags it by the configured capture depth.
        cyc("din", 7'b0000001, 5'b00000, 0);
        cyc("din", 7'b0000000, 5'b00000, 0);
        cyc("din", 7'b0000001, 5'b00000, 0);
        cyc("din", 7'b0000001, 5'b00000, 0);
        cyc("din", 7'b0000000, 5'b00000, 0);
        cyc("din", 7'b0000000, 5'b00000, 0);
        cyc("din", 7'b0000001, 5'b00000, 0);
        cyc("din", 7'b0000000, 5'b00000, 0);
        cyc("din", 7'b0000000, 5'b00000, 0);

        // Random traffic with invariant checks.
        for (int i = 0; i < 3000; i++) begin
            @(posedge UserCLK);
            #1;
            rand_phase = 1'b1;
            if ($urandom_range(0, 5) == 0) bus.req_a = ~bus.req_a;
            if ($urandom_range(0, 5) == 0) bus.req_b = ~bus.req_b;
            bus.oe_a   = 1'($urandom_range(0, 1));
            bus.oe_b   = 1'($urandom_range(0, 1));
            bus.dout_a = 1'($urandom_range(0, 1));
            bus.dout_b = 1'($urandom_range(0, 1));
            bus.pad_i  = 1'($urandom_range(0, 1));
        end
        @(posedge UserCLK);
        #1;
        {bus.req_a, bus.req_b, bus.oe_a, bus.oe_b, bus.dout_a, bus.dout_b, bus.pad_i} = 7'b0;
        repeat (MH + TA + 4) @(posedge UserCLK);
        #1 rand_phase = 1'b0;
        repeat (2) @(posedge UserCLK);
        #6;

        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending entries, want 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
